l1mtx_out_arb_m0: RTL and testbench
===================================

// Module: l1mtx_out_arb_m0
// PURPOSE
//  Round-robin arbiter for bus-matrix output stage MI0. Shares one AHB master port between
//  NUM_PORTS slave-side input stages whose decoders raise sel_dec0/active_dec0 per port.
//  Holds grant across bursts and locked sequences; tracks address- and data-phase owner
//  so the output stage muxes HADDR/control and the decoders route HREADYOUT/HRESP/HRDATA.
// PARAMETERS
//  NUM_PORTS  3  number of competing input stages (2..8)
//  PORT_W     2  width of encoded port index, >= clog2(NUM_PORTS)
// PORTS
//  HCLK            in   1            AHB clock; reset HRESETn, asynchronous, active-low; clock HCLK
//  HRESETn         in   1            asynchronous active-low reset
//  sel_op          in   NUM_PORTS    per-port select from each decoder (sel_decN)
//  trans_op        in   2*NUM_PORTS  per-port HTRANS, port i at [2i+1:2i]
//  lock_op         in   NUM_PORTS    per-port HMASTLOCK
//  HREADYM         in   1            HREADY from MI0 slave side (transfer completes)
//  addr_in_port    out  PORT_W       address-phase owner index (registered)
//  no_port         out  1            1 = no owner; output stage drives HTRANS=IDLE
//  data_in_port    out  PORT_W       data-phase owner index (registered)
//  data_no_port    out  1            1 = data phase is an IDLE/no-owner phase
//  active_op       out  NUM_PORTS    one-hot active to each decoder (active_decN)
//  HMASTLOCKM      out  1            registered lock for the granted port
// BEHAVIOUR
//  Reset: addr_in_port=0, no_port=1, data_in_port=0, data_no_port=1, HMASTLOCKM=0, active_op=0.
//  req[i] = sel_op[i] & trans_op[i][1] (NONSEQ or SEQ).
//  Hold condition (owner = addr_in_port, ~no_port): owner keeps grant if sel_op[owner] and
//   (trans_op[owner] is SEQ or BUSY, or lock_op[owner]=1). Hold overrides all other requests.
//  Otherwise next owner = first req[i] scanning (owner+1) mod NUM_PORTS upward, wrapping;
//   owner itself is checked last (lowest priority after service). No req -> next no_port=1,
//   addr_in_port keeps last value (park, preserves RR pointer).
//  Update: addr_in_port/no_port/HMASTLOCKM load next values only on posedge HCLK with HREADYM=1;
//   HREADYM=0 freezes all state (wait states never change ownership).
//  Data phase: on HREADYM=1, data_in_port<=addr_in_port, data_no_port<=no_port | ~trans_op[owner][1]
//   (IDLE/BUSY address phases produce no-owner data phase). 1-cycle lag from address owner.
//  active_op[i] = ~no_port & (addr_in_port==i); combinational from registers, glitch-free, one-hot.
//  HMASTLOCKM next = granted port's lock_op; lock released when owner presents lock_op=0 with
//   HREADYM=1; then normal arbitration resumes the same cycle.
//  Owner's sel_op drops mid-hold (decoder redirects to default slave): hold ends, rearbitrate.
//  Simultaneous new requests from all ports with no owner: pointer after last owner wins.
//  Reset asserted mid-burst: all outputs return to reset values asynchronously; no partial state.
//  Indices >= NUM_PORTS never produced; out-of-range internal state is an assertion failure.
// STRUCTURE
//  Shared package l1mtx_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ constants, clog2 function,
//   PORT_W derivation helper.
//  Sub-module l1mtx_rr_pick: combinational rotate-priority encoder (req vector + pointer ->
//   index + valid); top holds registers, hold logic, lock and data-phase tracking.
// TESTING
//  Reset: HRESETn=0 -> no_port=1, data_no_port=1, active_op=000, HMASTLOCKM=0.
//  RR fairness: ports 0,1,2 NONSEQ every cycle, HREADYM=1 -> grant order 0,1,2,0,1,2.
//  Burst hold: port 1 NONSEQ then 3 SEQ, port 2 requesting -> addr_in_port=1 for 4 beats, then 2.
//  Wait state: HREADYM=0 for 3 cycles while port 0 owns, port 2 requests -> no change until HREADYM=1.
//  Lock: port 2 lock_op=1 over 2 single NONSEQs with IDLE between -> HMASTLOCKM=1, grant held;
//   lock_op=0 -> port 0 granted next, HMASTLOCKM=0.
//  Data tracking: port 1 NONSEQ at cycle n -> data_in_port=1, data_no_port=0 at n+2 (HREADYM=1);
//   all IDLE -> no_port=1 and data_no_port=1 one update later; async reset mid-burst clears all.

Source files
------------

// File: rtl/l1mtx_pkg.sv
// Shared definitions for the bus-matrix output stages: HTRANS encodings and
// the width helpers used to size port-index fields.
package l1mtx_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // An index field is never narrower than one bit, even for a single port.
  function automatic int port_w(input int num_ports);
    return (num_ports < 2) ? 1 : clog2(num_ports);
  endfunction

endpackage

// File: rtl/l1mtx_rr_pick.sv
// Rotate-priority encoder: picks the first requester after ptr, wrapping,
// with ptr itself checked last.
module l1mtx_rr_pick #(
  parameter int NUM_PORTS = 3,
  parameter int PORT_W    = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [PORT_W-1:0]    idx,
  output logic                 valid
);

  int ptr_i;

  always_comb begin
    idx   = ptr;
    valid = 1'b0;
    ptr_i = 32'(ptr);
    for (int k = 1; k <= NUM_PORTS; k++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!valid && req[i] && (((ptr_i + k) % NUM_PORTS) == i)) begin
          valid = 1'b1;
          idx   = PORT_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/l1mtx_out_arb_m0.sv
// Round-robin arbiter for output stage MI0: tracks the address- and data-phase
// owner among the input stages, holding grant across bursts and locked sequences.
module l1mtx_out_arb_m0
  import l1mtx_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int PORT_W    = port_w(NUM_PORTS)
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_PORTS-1:0]   sel_op,
  input  logic [2*NUM_PORTS-1:0] trans_op,
  input  logic [NUM_PORTS-1:0]   lock_op,
  input  logic                   HREADYM,
  output logic [PORT_W-1:0]      addr_in_port,
  output logic                   no_port,
  output logic [PORT_W-1:0]      data_in_port,
  output logic                   data_no_port,
  output logic [NUM_PORTS-1:0]   active_op,
  output logic                   HMASTLOCKM
);

  // Handshake: HREADYM=1 at a rising edge completes the current data phase and
  // accepts the current address phase; HREADYM=0 stretches both, so every
  // register below loads only when HREADYM=1.

  logic [NUM_PORTS-1:0] req;
  logic [1:0]           owner_trans;
  logic                 owner_sel;
  logic                 owner_lock;
  logic                 hold;
  logic [PORT_W-1:0]    pick_idx;
  logic                 pick_valid;
  logic                 pick_lock;
  logic [PORT_W-1:0]    nxt_port;
  logic                 nxt_no;
  logic                 nxt_lock;

  always_comb begin
    req         = '0;
    owner_trans = HTRANS_IDLE;
    owner_sel   = 1'b0;
    owner_lock  = 1'b0;
    pick_lock   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[i] = sel_op[i] & trans_op[2*i+1];
      if (addr_in_port == PORT_W'(i)) begin
        owner_trans = trans_op[2*i +: 2];
        owner_sel   = sel_op[i];
        owner_lock  = lock_op[i];
      end
      if (pick_idx == PORT_W'(i)) pick_lock = lock_op[i];
    end
  end

  l1mtx_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (addr_in_port),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // A burst continuation or an asserted lock keeps the owner regardless of
  // other requests; losing sel_op (decoder redirect) always ends the hold.
  assign hold = ~no_port & owner_sel &
                ((owner_trans == HTRANS_SEQ) || (owner_trans == HTRANS_BUSY) || owner_lock);

  always_comb begin
    nxt_port = addr_in_port;
    nxt_no   = 1'b1;
    nxt_lock = 1'b0;
    if (hold) begin
      nxt_no   = 1'b0;
      nxt_lock = owner_lock;
    end else if (pick_valid) begin
      nxt_port = pick_idx;
      nxt_no   = 1'b0;
      nxt_lock = pick_lock;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port <= '0;
      no_port      <= 1'b1;
      HMASTLOCKM   <= 1'b0;
      data_in_port <= '0;
      data_no_port <= 1'b1;
    end else if (HREADYM) begin
      addr_in_port <= nxt_port;
      no_port      <= nxt_no;
      HMASTLOCKM   <= nxt_lock;
      data_in_port <= addr_in_port;
      data_no_port <= no_port | ~owner_trans[1];
    end
  end

  always_comb begin
    active_op = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      active_op[i] = ~no_port & (addr_in_port == PORT_W'(i));
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      assert (32'(addr_in_port) < NUM_PORTS);
      assert (32'(data_in_port) < NUM_PORTS);
      assert ($onehot0(active_op));
    end
  end

endmodule

// File: tb/tb_l1mtx_out_arb_m0.sv
// Directed bench for l1mtx_out_arb_m0: expected post-edge state is queued as
// each step is driven and compared once the edge has been taken.
module tb_l1mtx_out_arb_m0;
  import l1mtx_pkg::*;

  localparam int NP = 3;
  localparam int PW = 2;
  localparam int W  = 7;

  localparam logic [1:0] ID = HTRANS_IDLE;
  localparam logic [1:0] BZ = HTRANS_BUSY;
  localparam logic [1:0] NS = HTRANS_NONSEQ;
  localparam logic [1:0] SQ = HTRANS_SEQ;

  logic            HCLK;
  logic            HRESETn;
  logic [NP-1:0]   sel_op;
  logic [2*NP-1:0] trans_op;
  logic [NP-1:0]   lock_op;
  logic            HREADYM;
  logic [PW-1:0]   addr_in_port;
  logic            no_port;
  logic [PW-1:0]   data_in_port;
  logic            data_no_port;
  logic [NP-1:0]   active_op;
  logic            HMASTLOCKM;

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_errors;

  l1mtx_out_arb_m0 #(
    .NUM_PORTS (NP),
    .PORT_W    (PW)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .sel_op       (sel_op),
    .trans_op     (trans_op),
    .lock_op      (lock_op),
    .HREADYM      (HREADYM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port),
    .data_in_port (data_in_port),
    .data_no_port (data_no_port),
    .active_op    (active_op),
    .HMASTLOCKM   (HMASTLOCKM)
  );

  // Clock and reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Expected state packing: {addr_in_port, no_port, HMASTLOCKM, data_in_port, data_no_port}
  function automatic logic [W-1:0] ex(input int a, input bit n, input bit l, input int d, input bit dn);
    return {2'(a), n, l, 2'(d), dn};
  endfunction

  function automatic logic [2*NP-1:0] tr(input logic [1:0] t0, input logic [1:0] t1, input logic [1:0] t2);
    return {t2, t1, t0};
  endfunction

  // Scoreboard: pop the oldest expectation and compare state plus active_op
  task automatic check_out(input string tag);
    logic [W-1:0]  exp_v;
    logic [W-1:0]  obs_v;
    logic [NP-1:0] exp_act;
    exp_v = exp_q.pop_front();
    obs_v = {addr_in_port, no_port, HMASTLOCKM, data_in_port, data_no_port};
    n_checks++;
    assert (obs_v === exp_v) else begin
      n_errors++;
      $error("FAIL %s state: observed %b expected %b", tag, obs_v, exp_v);
    end
    exp_act = exp_v[4] ? '0 : NP'(1 << exp_v[6:5]);
    n_checks++;
    assert (active_op === exp_act) else begin
      n_errors++;
      $error("FAIL %s active_op: observed %b expected %b", tag, active_op, exp_act);
    end
  endtask

  // Driver: apply one cycle of inputs, take the edge, check the result
  task automatic step(input string tag, input logic [NP-1:0] sel, input logic [2*NP-1:0] trans,
                      input logic [NP-1:0] lock, input logic rdy, input logic [W-1:0] exp_v);
    exp_q.push_back(exp_v);
    sel_op   = sel;
    trans_op = trans;
    lock_op  = lock;
    HREADYM  = rdy;
    @(posedge HCLK);
    #1;
    check_out(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    HRESETn  = 1'b0;
    sel_op   = '0;
    trans_op = '0;
    lock_op  = '0;
    HREADYM  = 1'b1;
    #12;
    exp_q.push_back(ex(0, 1, 0, 0, 1));
    check_out("reset");
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Round-robin fairness: port 0 alone, then all three every cycle
    step("rr0", 3'b001, tr(NS, ID, ID), 3'b000, 1'b1, ex(0, 0, 0, 0, 1));
    step("rr1", 3'b111, tr(NS, NS, NS), 3'b000, 1'b1, ex(1, 0, 0, 0, 0));
    step("rr2", 3'b111, tr(NS, NS, NS), 3'b000, 1'b1, ex(2, 0, 0, 1, 0));
    step("rr3", 3'b111, tr(NS, NS, NS), 3'b000, 1'b1, ex(0, 0, 0, 2, 0));
    step("rr4", 3'b111, tr(NS, NS, NS), 3'b000, 1'b1, ex(1, 0, 0, 0, 0));
    step("rr5", 3'b111, tr(NS, NS, NS), 3'b000, 1'b1, ex(2, 0, 0, 1, 0));

    // Burst hold: port 1 NONSEQ + 3 SEQ while port 2 keeps requesting
    step("burst0", 3'b110, tr(ID, NS, NS), 3'b000, 1'b1, ex(1, 0, 0, 2, 0));
    step("burst1", 3'b110, tr(ID, SQ, NS), 3'b000, 1'b1, ex(1, 0, 0, 1, 0));
    step("burst2", 3'b110, tr(ID, SQ, NS), 3'b000, 1'b1, ex(1, 0, 0, 1, 0));
    step("burst3", 3'b110, tr(ID, SQ, NS), 3'b000, 1'b1, ex(1, 0, 0, 1, 0));
    step("burst_end", 3'b110, tr(ID, ID, NS), 3'b000, 1'b1, ex(2, 0, 0, 1, 1));

    // Wait states: port 0 owns, port 2 requests, HREADYM low for 3 cycles
    step("wait_own", 3'b101, tr(NS, ID, NS), 3'b000, 1'b1, ex(0, 0, 0, 2, 0));
    step("wait1", 3'b101, tr(SQ, ID, NS), 3'b000, 1'b0, ex(0, 0, 0, 2, 0));
    step("wait2", 3'b101, tr(BZ, ID, NS), 3'b100, 1'b0, ex(0, 0, 0, 2, 0));
    step("wait3", 3'b101, tr(SQ, ID, NS), 3'b000, 1'b0, ex(0, 0, 0, 2, 0));
    step("wait_rel", 3'b101, tr(ID, ID, NS), 3'b000, 1'b1, ex(2, 0, 0, 0, 1));

    // Locked sequence on port 2 with an IDLE between two NONSEQs
    step("lock0", 3'b101, tr(NS, ID, NS), 3'b100, 1'b1, ex(2, 0, 1, 2, 0));
    step("lock1", 3'b101, tr(NS, ID, ID), 3'b100, 1'b1, ex(2, 0, 1, 2, 1));
    step("lock2", 3'b101, tr(NS, ID, NS), 3'b100, 1'b1, ex(2, 0, 1, 2, 0));
    step("unlock", 3'b101, tr(NS, ID, ID), 3'b000, 1'b1, ex(0, 0, 0, 2, 1));

    // Data-phase tracking, then park with no requests
    step("data0", 3'b010, tr(ID, NS, ID), 3'b000, 1'b1, ex(1, 0, 0, 0, 1));
    step("data1", 3'b010, tr(ID, NS, ID), 3'b000, 1'b1, ex(1, 0, 0, 1, 0));
    step("idle0", 3'b000, tr(ID, ID, ID), 3'b000, 1'b1, ex(1, 1, 0, 1, 1));
    step("idle1", 3'b000, tr(ID, ID, ID), 3'b000, 1'b1, ex(1, 1, 0, 1, 1));

    // All request from park: pointer after last owner (1) wins
    step("park_all", 3'b111, tr(NS, NS, NS), 3'b000, 1'b1, ex(2, 0, 0, 1, 1));

    // Owner's sel drops mid-burst: hold ends, port 1 picked
    step("sel_drop", 3'b010, tr(ID, NS, SQ), 3'b000, 1'b1, ex(1, 0, 0, 2, 0));
    step("lock_burst", 3'b010, tr(ID, SQ, ID), 3'b010, 1'b1, ex(1, 0, 1, 1, 0));

    // Asynchronous reset between edges clears everything
    #2;
    HRESETn = 1'b0;
    #1;
    exp_q.push_back(ex(0, 1, 0, 0, 1));
    check_out("async_rst");
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Random inputs with HREADYM low never disturb the reset state
    for (int k = 0; k < 4; k++) begin
      step("rand_wait", NP'($urandom_range(0, 7)), (2*NP)'($urandom_range(0, 63)),
           NP'($urandom_range(0, 7)), 1'b0, ex(0, 1, 0, 0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
